// File: rtl/atomic_alu_sequencer_if.sv
// Command, ALU, response, host-write and debug-read bundle for atomic_alu_sequencer.
// The slave modport is the sequencer side; master is the host/ALU/consumer side.
interface atomic_alu_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int AW     = 3,
   parameter int OP_W   = 3
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [OP_W+3*AW-1:0]   cmd;

   logic [OP_W-1:0]        alu_op;
   logic [DATA_W-1:0]      alu_a;
   logic [DATA_W-1:0]      alu_b;
   logic [DATA_W-1:0]      alu_y;
   logic                   alu_o;
   logic                   alu_c;
   logic                   alu_z;
   logic                   alu_n;

   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [DATA_W-1:0]      rsp_data;
   logic [3:0]             rsp_flags;
   logic                   rsp_cas_ok;

   logic                   host_we;
   logic [AW-1:0]          host_waddr;
   logic [DATA_W-1:0]      host_wdata;

   logic [AW-1:0]          dbg_raddr;
   logic [DATA_W-1:0]      dbg_rdata;

   modport slave (
      input  cmd_valid, cmd,
      output cmd_ready,
      output alu_op, alu_a, alu_b,
      input  alu_y, alu_o, alu_c, alu_z, alu_n,
      output rsp_valid, rsp_data, rsp_flags, rsp_cas_ok,
      input  rsp_ready,
      input  host_we, host_waddr, host_wdata,
      input  dbg_raddr,
      output dbg_rdata
   );

   modport master (
      output cmd_valid, cmd,
      input  cmd_ready,
      input  alu_op, alu_a, alu_b,
      output alu_y, alu_o, alu_c, alu_z, alu_n,
      input  rsp_valid, rsp_data, rsp_flags, rsp_cas_ok,
      output rsp_ready,
      output host_we, host_waddr, host_wdata,
      output dbg_raddr,
      input  dbg_rdata
   );
endinterface

// File: rtl/atomic_alu_sequencer.sv
// Command sequencer owning the register file that feeds an external combinational ALU.
// Optional macro ZERO_REG_EN makes register 0 a hardwired zero.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cmd_ready high, waiting for cmd_valid
// READ  | drive alu_a/alu_b/alu_op from the register file
// EXEC  | sample ALU result/flags, perform writeback or CAS swap
// RESP  | rsp_valid high, hold response until rsp_ready
module atomic_alu_sequencer #(
   parameter int              DATA_W     = 32,
   parameter int              NREGS      = 8,
   parameter int              AW         = $clog2(NREGS),
   parameter int              OP_W       = 3,
   parameter logic [OP_W-1:0] CAS_OP     = 3'b111,
   parameter logic [OP_W-1:0] CAS_SUB_OP = 3'b001
) (
   input  logic                    clk,
   input  logic                    rst_n,
   atomic_alu_sequencer_if.slave   bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_EXEC = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

`ifdef ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   logic [1:0]         state;
   logic [OP_W-1:0]    op_q;
   logic [AW-1:0]      a1_q;
   logic [AW-1:0]      a2_q;
   logic [AW-1:0]      a3_q;

   logic [DATA_W-1:0]  regs [NREGS];

   logic [OP_W-1:0]    alu_op_q;
   logic [DATA_W-1:0]  alu_a_q;
   logic [DATA_W-1:0]  alu_b_q;
   logic [DATA_W-1:0]  rsp_data_q;
   logic [3:0]         rsp_flags_q;
   logic               rsp_cas_ok_q;

   logic               is_cas;
   logic [DATA_W-1:0]  rf_a1;
   logic [DATA_W-1:0]  rf_a2;
   logic [DATA_W-1:0]  rf_a3;
   logic               wb_en;
   logic [AW-1:0]      wb_addr;
   logic [DATA_W-1:0]  wb_data;
   logic               host_en;

   function automatic logic [DATA_W-1:0] rf_read(input logic [AW-1:0] addr);
      if (ZERO_REG && (addr == '0)) begin
         return '0;
      end
      return regs[addr];
   endfunction

   assign is_cas = (op_q == CAS_OP);
   assign rf_a1  = rf_read(a1_q);
   assign rf_a2  = rf_read(a2_q);
   assign rf_a3  = rf_read(a3_q);

   // A CAS swap writes the pre-edge value of reg[a3] into reg[a1]; plain ops write alu_y to a3.
   always_comb begin
      wb_en   = 1'b0;
      wb_addr = a3_q;
      wb_data = bus.alu_y;
      if (state == S_EXEC) begin
         if (!is_cas) begin
            wb_en = 1'b1;
         end else if (bus.alu_z) begin
            wb_en   = 1'b1;
            wb_addr = a1_q;
            wb_data = rf_a3;
         end
      end
      if (ZERO_REG && (wb_addr == '0)) begin
         wb_en = 1'b0;
      end
   end

   assign host_en = bus.host_we && !(ZERO_REG && (bus.host_waddr == '0));

   // Internal writeback has priority over a host write to the same register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (wb_en && (wb_addr == AW'(i))) begin
               regs[i] <= wb_data;
            end else if (host_en && (bus.host_waddr == AW'(i))) begin
               regs[i] <= bus.host_wdata;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         op_q         <= '0;
         a1_q         <= '0;
         a2_q         <= '0;
         a3_q         <= '0;
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rsp_data_q   <= '0;
         rsp_flags_q  <= '0;
         rsp_cas_ok_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  op_q  <= bus.cmd[OP_W+3*AW-1 -: OP_W];
                  a1_q  <= bus.cmd[3*AW-1 -: AW];
                  a2_q  <= bus.cmd[2*AW-1 -: AW];
                  a3_q  <= bus.cmd[AW-1:0];
                  state <= S_READ;
               end
            end
            S_READ: begin
               alu_a_q  <= rf_a1;
               alu_b_q  <= rf_a2;
               alu_op_q <= is_cas ? CAS_SUB_OP : op_q;
               state    <= S_EXEC;
            end
            S_EXEC: begin
               rsp_flags_q <= {bus.alu_o, bus.alu_c, bus.alu_z, bus.alu_n};
               if (is_cas) begin
                  rsp_data_q   <= alu_a_q;
                  rsp_cas_ok_q <= bus.alu_z;
               end else begin
                  rsp_data_q   <= bus.alu_y;
                  rsp_cas_ok_q <= 1'b0;
               end
               state <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready  = (state == S_IDLE);
   assign bus.rsp_valid  = (state == S_RESP);
   assign bus.alu_op     = alu_op_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.rsp_cas_ok = rsp_cas_ok_q;
   assign bus.dbg_rdata  = rf_read(bus.dbg_raddr);

endmodule
